// File: rtl/subn_serial.sv
// Bit-serial n-bit subtractor: {Bout, Diff} = X - Y - Bin, one bit per clock, LSB first.
// Optional signed-overflow output V is enabled by defining SUBN_OVERFLOW_EN.
module subn_serial #(
    parameter int n = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Bin,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    output logic [n-1:0] Diff,
    output logic         Bout,
`ifdef SUBN_OVERFLOW_EN
    output logic         V,
`endif
    output logic         Busy,
    output logic         Done
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            b_q, b_d;
    logic [n-1:0]    x_q, x_d;
    logic [n-1:0]    y_q, y_d;
    logic [n-1:0]    res_q, res_d;
    logic [n-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
`ifdef SUBN_OVERFLOW_EN
    logic            v_q, v_d;
`endif

    logic            d_bit;
    logic            b_next;
    logic [n:0]      res_ext;
    logic [n-1:0]    res_shift;

    // Full-subtractor cell on the current LSBs and the borrow flop.
    assign d_bit     = x_q[0] ^ y_q[0] ^ b_q;
    assign b_next    = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);
    assign res_ext   = {d_bit, res_q};
    assign res_shift = res_ext[n:1];

    // Handshake: Start is accepted on a rising edge only in IDLE or DONE;
    // Busy is high for the n RUN cycles, Done pulses for exactly one cycle
    // and Diff/Bout are valid from that cycle until the next completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUBN_OVERFLOW_EN
        v_d     = v_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    x_d     = X;
                    y_d     = Y;
                    b_d     = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                b_d   = b_next;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = b_next;
`ifdef SUBN_OVERFLOW_EN
                    // On the last bit the operand LSBs are the captured MSBs.
                    v_d     = (x_q[0] ^ y_q[0]) & (x_q[0] ^ d_bit);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUBN_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUBN_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SUBN_OVERFLOW_EN
    assign V    = v_q;
`endif
    assign Busy = (state_q == RUN);
    assign Done = (state_q == DONE);

endmodule
